// File: rtl/rv32i_stage_ctrl.sv
// -----------------------------------------------------------------------------
// rv32i_stage_ctrl
//   Multi-cycle RV32I stage sequencer: FETCH -> DECODE -> EXECUTE ->
//   MEMORYACCESS -> WRITEBACK, with bus-wait timeout, fault flag and a
//   saturating stall counter.
//
// Parameters
//   TIMEOUT_CYCLES  un-acknowledged bus-wait cycles before a fault (0 = off)
//   STALL_CNT_W     width of stall_cnt
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   pc                         current program counter
//   ibus_req/addr/ack/inst     instruction fetch handshake
//   opcode_load, opcode_store  decoded opcode flags
//   dbus_req/ack               data access handshake
//   inst_q                     registered instruction
//   *_stage                    one-hot stage flags
//   done_tick                  end-of-instruction pulse (WRITEBACK)
//   bus_err                    timeout pulse
//   fault_q                    current instruction faulted
//   stall_cnt                  accumulated bus-wait cycles
//
// Build option
//   RV32I_FAST_STAGE_EN  defined: non-load/store instructions skip
//                        MEMORYACCESS (4-cycle minimum instruction).
// -----------------------------------------------------------------------------
module rv32i_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            pc,
    output logic                   ibus_req,
    output logic [31:0]            ibus_addr,
    input  logic                   ibus_ack,
    input  logic [31:0]            ibus_inst,
    input  logic                   opcode_load,
    input  logic                   opcode_store,
    output logic                   dbus_req,
    input  logic                   dbus_ack,
    output logic [31:0]            inst_q,
    output logic                   fetch_stage,
    output logic                   decode_stage,
    output logic                   alu_stage,
    output logic                   memoryaccess_stage,
    output logic                   writeback_stage,
    output logic                   done_tick,
    output logic                   bus_err,
    output logic                   fault_q,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEMORYACCESS,
        WRITEBACK
    } state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam bit          TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_e                 state_q, state_d;
    logic [31:0]            inst_d;
    logic [31:0]            wait_q, wait_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   fault_d;

    logic ibus_req_raw, dbus_req_raw, bus_err_raw;
    logic ls;
    logic timeout_hit;

    assign ls          = opcode_load | opcode_store;
    assign timeout_hit = TO_EN && (wait_q == TO_LAST);
    assign ibus_addr   = pc;
    assign stall_cnt   = stall_q;

    // Requests and the error pulse are gated by rst_n so that an in-flight
    // access is dropped the moment reset asserts, not at the next edge.
    assign ibus_req = ibus_req_raw & rst_n;
    assign dbus_req = dbus_req_raw & rst_n;
    assign bus_err  = bus_err_raw  & rst_n;

    always_comb begin
        state_d            = state_q;
        inst_d             = inst_q;
        wait_d             = wait_q;
        stall_d            = stall_q;
        fault_d            = fault_q;
        ibus_req_raw       = 1'b0;
        dbus_req_raw       = 1'b0;
        bus_err_raw        = 1'b0;
        done_tick          = 1'b0;
        fetch_stage        = 1'b0;
        decode_stage       = 1'b0;
        alu_stage          = 1'b0;
        memoryaccess_stage = 1'b0;
        writeback_stage    = 1'b0;

        case (state_q)
            FETCH: begin
                fetch_stage  = 1'b1;
                ibus_req_raw = 1'b1;
                if (ibus_ack) begin
                    // An ack in the timeout cycle still wins.
                    inst_d  = ibus_inst;
                    state_d = DECODE;
                end else begin
                    if (stall_q != '1) stall_d = stall_q + STALL_CNT_W'(1);
                    if (timeout_hit) begin
                        bus_err_raw = 1'b1;
                        fault_d     = 1'b1;
                        inst_d      = NOP_INST;
                        state_d     = DECODE;
                    end else if (wait_q != '1) begin
                        wait_d = wait_q + 32'd1;
                    end
                end
            end

            DECODE: begin
                decode_stage = 1'b1;
                state_d      = EXECUTE;
            end

            EXECUTE: begin
                alu_stage = 1'b1;
`ifdef RV32I_FAST_STAGE_EN
                if (ls) begin
                    state_d = MEMORYACCESS;
                    wait_d  = '0;
                end else begin
                    state_d = WRITEBACK;
                end
`else
                state_d = MEMORYACCESS;
                wait_d  = '0;
`endif
            end

            MEMORYACCESS: begin
                memoryaccess_stage = 1'b1;
                if (ls) begin
                    dbus_req_raw = 1'b1;
                    if (dbus_ack) begin
                        state_d = WRITEBACK;
                    end else begin
                        if (stall_q != '1) stall_d = stall_q + STALL_CNT_W'(1);
                        if (timeout_hit) begin
                            bus_err_raw = 1'b1;
                            fault_d     = 1'b1;
                            state_d     = WRITEBACK;
                        end else if (wait_q != '1) begin
                            wait_d = wait_q + 32'd1;
                        end
                    end
                end else begin
                    state_d = WRITEBACK;
                end
            end

            WRITEBACK: begin
                writeback_stage = 1'b1;
                done_tick       = 1'b1;
                state_d         = FETCH;
                fault_d         = 1'b0;
                wait_d          = '0;
            end

            default: begin
                state_d = FETCH;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            inst_q  <= NOP_INST;
            wait_q  <= '0;
            stall_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_rv32i_stage_ctrl.sv
module tb_rv32i_stage_ctrl;

    localparam int          T       = 16;
    localparam int          NEVER   = 1000;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ADD     = 32'h0020_81B3;

    logic        clk, rst_n;
    logic [31:0] pc;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_inst;
    logic        opcode_load, opcode_store;
    logic        dbus_req, dbus_ack;
    logic [31:0] inst_q;
    logic        fetch_stage, decode_stage, alu_stage, memoryaccess_stage, writeback_stage;
    logic        done_tick, bus_err, fault_q;
    logic [15:0] stall_cnt;

    rv32i_stage_ctrl #(.TIMEOUT_CYCLES(T), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ack(ibus_ack), .ibus_inst(ibus_inst),
        .opcode_load(opcode_load), .opcode_store(opcode_store),
        .dbus_req(dbus_req), .dbus_ack(dbus_ack), .inst_q(inst_q),
        .fetch_stage(fetch_stage), .decode_stage(decode_stage), .alu_stage(alu_stage),
        .memoryaccess_stage(memoryaccess_stage), .writeback_stage(writeback_stage),
        .done_tick(done_tick), .bus_err(bus_err), .fault_q(fault_q), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    bit abort  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Expected per-instruction outcome, observed at done_tick.
    typedef struct {
        int          len;
        logic [31:0] inst;
        bit          fault;
        int          stall;
        int          berr;
    } exp_t;

    exp_t exp_q[$];
    int   model_stall = 0;

    // ---------------- monitor (samples on negedge) ----------------
    int   mlen = 0;
    int   mberr = 0;
    bit   after_done = 0;
    exp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            mlen = 0; mberr = 0; after_done = 0;
        end else begin
            mlen++;
            check("onehot", 32'($countones({fetch_stage, decode_stage, alu_stage,
                                             memoryaccess_stage, writeback_stage})), 32'd1);
            if (ibus_req) check("ibus_addr", ibus_addr, pc);
            if (after_done) begin
                check("fault_clear_in_fetch", {31'd0, fault_q}, 32'd0);
                check("fetch_after_done", {31'd0, fetch_stage}, 32'd1);
                after_done = 0;
            end
            if (bus_err) mberr++;
            if (done_tick) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL done_unexpected: got done_tick expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("instr_len", 32'(mlen), 32'(e.len));
                    check("inst_q", inst_q, e.inst);
                    check("fault_q", {31'd0, fault_q}, {31'd0, e.fault});
                    check("stall_cnt", {16'd0, stall_cnt}, 32'(e.stall));
                    check("bus_err_pulses", 32'(mberr), 32'(e.berr));
                end
                mlen = 0; mberr = 0; after_done = 1;
            end
        end
    end

    // ---------------- stimulus + reference model ----------------
    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // fd/dd: number of un-acked request cycles before the ack (>= T: never acked in time)
    task automatic run_instr(input int fd, input int dd, input int kind, input logic [31:0] inst);
        exp_t x;
        int   fcyc, mcyc, k, j, guard;
        bit   isls, fto, dto;
        isls = (kind != 0);
        fto  = (fd >= T);
        fcyc = imin(fd + 1, T);
        model_stall += imin(fd, T);
        dto  = 0;
        if (isls) begin
            dto  = (dd >= T);
            mcyc = imin(dd + 1, T);
            model_stall += imin(dd, T);
        end else begin
`ifdef RV32I_FAST_STAGE_EN
            mcyc = 0;
`else
            mcyc = 1;
`endif
        end
        if (model_stall > 65535) model_stall = 65535;
        x.len   = fcyc + 2 + mcyc + 1;
        x.inst  = fto ? NOP : inst;
        x.fault = fto | dto;
        x.stall = model_stall;
        x.berr  = int'(fto) + int'(dto);
        exp_q.push_back(x);

        opcode_load  = (kind == 1);
        opcode_store = (kind == 2);
        k = 0; guard = 0;
        forever begin
            pc = $urandom;
            if (ibus_req) begin
                ibus_ack  = (k == fd);
                ibus_inst = (k == fd) ? inst : $urandom;
                k++;
            end else begin
                if (k > 0) break;
                ibus_ack = 1'($urandom_range(0, 1));
            end
            guard++;
            if (guard > 200) begin
                checks++; abort = 1;
                $display("FAIL fetch_wait_bound: got no fetch completion expected within 200 cycles");
                return;
            end
            @(posedge clk); #1;
        end
        j = 0; guard = 0;
        while (!writeback_stage) begin
            pc        = $urandom;
            ibus_ack  = 1'($urandom_range(0, 1));
            ibus_inst = $urandom;
            if (dbus_req) begin
                dbus_ack = (j == dd);
                j++;
            end else begin
                dbus_ack = 1'($urandom_range(0, 1));
            end
            guard++;
            if (guard > 200) begin
                checks++; abort = 1;
                $display("FAIL data_wait_bound: got no writeback expected within 200 cycles");
                return;
            end
            @(posedge clk); #1;
        end
        pc       = $urandom;
        ibus_ack = 1'($urandom_range(0, 1));
        dbus_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
    endtask

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2, 3: return 0;
            4, 5:       return $urandom_range(1, 5);
            6:          return T - 1;
            7:          return T;
            8:          return NEVER;
            default:    return $urandom_range(6, 14);
        endcase
    endfunction

    initial begin
        rst_n = 0; pc = '0; ibus_ack = 0; ibus_inst = '0;
        opcode_load = 0; opcode_store = 0; dbus_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fetch_stage", {31'd0, fetch_stage}, 32'd1);
        check("rst_inst_q", inst_q, NOP);
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst_fault_q", {31'd0, fault_q}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_done_tick", {31'd0, done_tick}, 32'd0);
        check("rst_dbus_req", {31'd0, dbus_req}, 32'd0);
        check("rst_ibus_req", {31'd0, ibus_req}, 32'd0);
        rst_n = 1;
        #1;
        check("ibus_req_after_reset", {31'd0, ibus_req}, 32'd1);

        // zero-wait ALU instructions
        for (int i = 0; i < 6 && !abort; i++) run_instr(0, 0, 0, ADD);
        // fetch ack delayed 3 cycles
        if (!abort) run_instr(3, 0, 0, ADD + 32'h100);
        // load never acked -> data timeout
        if (!abort) run_instr(0, NEVER, 1, 32'h0000_2083);
        // load acked in the 16th request cycle -> no error
        if (!abort) run_instr(0, T - 1, 1, 32'h0040_2103);
        // store with short wait
        if (!abort) run_instr(1, 2, 2, 32'h0020_A023);
        // fetch never acked -> NOP loaded
        if (!abort) run_instr(NEVER, 0, 0, ADD);
        // fetch acked in the 16th request cycle
        if (!abort) run_instr(T - 1, 0, 0, 32'h0010_0093);

        for (int i = 0; i < 60 && !abort; i++)
            run_instr(pick_delay(), pick_delay(), $urandom_range(0, 2), $urandom);

        // reset pulsed during a data wait
        if (!abort) begin
            bit seen;
            seen = 0;
            ibus_ack = 1; ibus_inst = ADD; opcode_load = 1; opcode_store = 0; dbus_ack = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                ibus_ack = 0;
                if (dbus_req) begin seen = 1; break; end
            end
            check("reach_data_wait", {31'd0, seen}, 32'd1);
            // the pending instruction is never pushed; keep the model clean
            repeat (3) @(posedge clk);
            #3;
            rst_n = 0;
            #1;
            check("async_dbus_req_drop", {31'd0, dbus_req}, 32'd0);
            check("async_ibus_req_drop", {31'd0, ibus_req}, 32'd0);
            model_stall = 0;
            @(posedge clk); #1;
            rst_n = 1;
            #1;
            check("post_rst_fetch", {31'd0, fetch_stage}, 32'd1);
            check("post_rst_stall", {16'd0, stall_cnt}, 32'd0);
            check("post_rst_inst_q", inst_q, NOP);
            for (int i = 0; i < 3 && !abort; i++) run_instr(pick_delay(), 2, 1, $urandom);
        end

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
